// File: rtl/mem_access_if.sv
// Data-memory request/acknowledge port between the mem_access stage (master) and memory (slave).
interface mem_access_if;
  logic        MEM_REQ;
  logic        MEM_WE;
  logic [31:0] MEM_ADDR;
  logic [3:0]  MEM_WSTRB;
  logic [31:0] MEM_WDATA;
  logic [31:0] MEM_RDATA;
  logic        MEM_ACK;

  modport master (
    output MEM_REQ, MEM_WE, MEM_ADDR, MEM_WSTRB, MEM_WDATA,
    input  MEM_RDATA, MEM_ACK
  );

  modport slave (
    input  MEM_REQ, MEM_WE, MEM_ADDR, MEM_WSTRB, MEM_WDATA,
    output MEM_RDATA, MEM_ACK
  );
endinterface

// File: rtl/mem_access.sv
// RV32I memory-access stage: passes ALU bundles through in one cycle and runs
// LB/LH/LW/LBU/LHU/SB/SH/SW on a req/ack bus, holding upstream while busy.
module mem_access (
  input  logic        CLK,
  input  logic        RST,
  input  logic        STALL,
  input  logic [31:0] A_PC,
  input  logic [31:0] A_INST,
  input  logic        A_VALID,
  input  logic [4:0]  A_REG_D,
  input  logic [31:0] A_REG_D_V,
  input  logic [31:0] A_MEM_ADDR,
  input  logic [31:0] A_STORE_DATA,
  output logic [31:0] M_PC,
  output logic [31:0] M_INST,
  output logic        M_VALID,
  output logic [4:0]  M_REG_D,
  output logic [31:0] M_REG_D_V,
  output logic        M_MISALIGN,
  output logic        MEM_BUSY,
  mem_access_if.master mem
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t r_state;
  state_t w_next;

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_inst;
  logic            r_valid;
  logic [RW-1:0]   r_reg_d;
  logic [XLEN-1:0] r_reg_d_v;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_sdata;
  logic [XLEN-1:0] r_rdata;

  logic            w_cap;
  logic            w_a_go;
  logic            w_ld;
  logic            w_st;
  logic            w_mis;
  logic [2:0]      w_f3;
  logic [3:0]      w_wstrb;
  logic [XLEN-1:0] w_wdata;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [XLEN-1:0] w_load;

  function automatic logic f_is_ld(input logic [6:0] opc, input logic [2:0] f3);
    return (opc == OPC_LOAD) &&
           (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010 || f3 == 3'b100 || f3 == 3'b101);
  endfunction

  function automatic logic f_is_st(input logic [6:0] opc, input logic [2:0] f3);
    return (opc == OPC_STORE) && (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010);
  endfunction

  // Halfwords need addr[0]=0, words need addr[1:0]=0; bytes are always aligned.
  function automatic logic f_mis(input logic [2:0] f3, input logic [1:0] a);
    return ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
  endfunction

  assign w_cap  = !STALL && (r_state != S_REQ);
  assign w_a_go = A_VALID &&
                  (f_is_ld(A_INST[6:0], A_INST[14:12]) || f_is_st(A_INST[6:0], A_INST[14:12])) &&
                  !f_mis(A_INST[14:12], A_MEM_ADDR[1:0]);

  assign w_f3  = r_inst[14:12];
  assign w_ld  = f_is_ld(r_inst[6:0], w_f3);
  assign w_st  = f_is_st(r_inst[6:0], w_f3);
  assign w_mis = (w_ld || w_st) && f_mis(w_f3, r_addr[1:0]);

  // Stage registers and read-data capture
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pc      <= '0;
      r_inst    <= '0;
      r_valid   <= 1'b0;
      r_reg_d   <= '0;
      r_reg_d_v <= '0;
      r_addr    <= '0;
      r_sdata   <= '0;
      r_rdata   <= '0;
    end else begin
      if (w_cap) begin
        r_pc      <= A_PC;
        r_inst    <= A_INST;
        r_valid   <= A_VALID;
        r_reg_d   <= A_REG_D;
        r_reg_d_v <= A_REG_D_V;
        r_addr    <= A_MEM_ADDR;
        r_sdata   <= A_STORE_DATA;
      end
      if ((r_state == S_REQ) && mem.MEM_ACK) begin
        r_rdata <= mem.MEM_RDATA;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Store lane steering and load extraction
  always_comb begin
    w_wstrb = 4'b1111;
    w_wdata = r_sdata;
    case (w_f3[1:0])
      2'b00: begin
        w_wstrb = 4'b0001 << r_addr[1:0];
        w_wdata = {4{r_sdata[7:0]}};
      end
      2'b01: begin
        w_wstrb = 4'b0011 << r_addr[1:0];
        w_wdata = {2{r_sdata[15:0]}};
      end
      default: ;
    endcase

    w_byte = r_rdata[7:0];
    case (r_addr[1:0])
      2'd1:    w_byte = r_rdata[15:8];
      2'd2:    w_byte = r_rdata[23:16];
      2'd3:    w_byte = r_rdata[31:24];
      default: ;
    endcase
    w_half = r_addr[1] ? r_rdata[31:16] : r_rdata[15:0];

    w_load = r_rdata;
    case (w_f3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b100:  w_load = {24'h0, w_byte};
      3'b101:  w_load = {16'h0, w_half};
      default: ;
    endcase
  end

  always_comb begin
    w_next        = r_state;
    M_PC          = r_pc;
    M_INST        = r_inst;
    M_VALID       = 1'b0;
    M_REG_D       = '0;
    M_REG_D_V     = '0;
    M_MISALIGN    = 1'b0;
    MEM_BUSY      = 1'b0;
    mem.MEM_REQ   = 1'b0;
    mem.MEM_WE    = 1'b0;
    mem.MEM_ADDR  = '0;
    mem.MEM_WSTRB = '0;
    mem.MEM_WDATA = '0;

    case (r_state)
      S_IDLE: begin
        M_VALID = r_valid;
        if (w_mis) begin
          M_MISALIGN = r_valid;
        end else begin
          M_REG_D   = r_reg_d;
          M_REG_D_V = r_reg_d_v;
        end
        if (!STALL) w_next = w_a_go ? S_REQ : S_IDLE;
      end
      S_REQ: begin
        MEM_BUSY      = 1'b1;
        mem.MEM_REQ   = 1'b1;
        mem.MEM_WE    = w_st;
        mem.MEM_ADDR  = {r_addr[XLEN-1:2], 2'b00};
        mem.MEM_WSTRB = w_st ? w_wstrb : 4'b0000;
        mem.MEM_WDATA = w_wdata;
        if (mem.MEM_ACK) w_next = S_DONE;
      end
      S_DONE: begin
        M_VALID = 1'b1;
        if (w_ld) begin
          M_REG_D   = r_reg_d;
          M_REG_D_V = w_load;
        end
        if (!STALL) w_next = w_a_go ? S_REQ : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access.sv
// Randomized scoreboard bench for mem_access: a driver issues bundles, a memory
// responder serves the bus, and a monitor compares outputs against a reference model.
module tb_mem_access;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        STALL = 1'b0;
  logic [31:0] A_PC = '0, A_INST = '0, A_REG_D_V = '0, A_MEM_ADDR = '0, A_STORE_DATA = '0;
  logic        A_VALID = 1'b0;
  logic [4:0]  A_REG_D = '0;
  logic [31:0] M_PC, M_INST, M_REG_D_V;
  logic        M_VALID, M_MISALIGN, MEM_BUSY;
  logic [4:0]  M_REG_D;

  mem_access_if mem_bus();

  mem_access dut (
    .CLK(CLK), .RST(RST), .STALL(STALL),
    .A_PC(A_PC), .A_INST(A_INST), .A_VALID(A_VALID), .A_REG_D(A_REG_D),
    .A_REG_D_V(A_REG_D_V), .A_MEM_ADDR(A_MEM_ADDR), .A_STORE_DATA(A_STORE_DATA),
    .M_PC(M_PC), .M_INST(M_INST), .M_VALID(M_VALID), .M_REG_D(M_REG_D),
    .M_REG_D_V(M_REG_D_V), .M_MISALIGN(M_MISALIGN), .MEM_BUSY(MEM_BUSY),
    .mem(mem_bus.master)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] pc, inst, rdv, addr, sdata, rdata;
    logic        valid;
    logic [4:0]  rd;
  } bundle_t;

  typedef struct {
    logic [31:0] pc, inst, rdv;
    logic [4:0]  rd;
    logic        mis;
  } out_t;

  typedef struct {
    logic        we;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  wstrb;
  } req_t;

  out_t exp_q[$];
  req_t req_q[$];
  int   checks = 0;
  int   errors = 0;
  int   stall_pct = 0;
  int   fixed_delay = -1;
  bit   resp_en = 1'b1;
  bit   man_ack = 1'b0;
  logic [31:0] man_rdata = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: architectural result and expected bus request of one bundle
  function automatic void model(input bundle_t b, output out_t o, output bit has_req, output req_t r);
    int f3, size, off;
    bit ld, st, mis;
    logic [31:0] v, mask;
    f3   = int'(b.inst[14:12]);
    ld   = (b.inst[6:0] == 7'h03) && (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    st   = (b.inst[6:0] == 7'h23) && (f3 <= 2);
    size = 1 << (f3 % 4);
    off  = int'(b.addr[1:0]);
    mis  = (ld || st) && ((off % size) != 0);
    o.pc = b.pc; o.inst = b.inst; o.rd = b.rd; o.rdv = b.rdv; o.mis = mis;
    r.we = 1'b0; r.addr = {b.addr[31:2], 2'b00}; r.wstrb = 4'h0; r.wdata = '0; r.rdata = b.rdata;
    has_req = (ld || st) && !mis;
    if (mis) begin
      o.rd = '0; o.rdv = '0;
    end else if (st) begin
      o.rd = '0; o.rdv = '0; r.we = 1'b1;
      for (int i = 0; i < 4; i++) begin
        r.wstrb[i] = (i >= off) && (i < off + size);
        r.wdata[8*i +: 8] = b.sdata[8*(i % size) +: 8];
      end
    end else if (ld) begin
      v = b.rdata >> (8 * off);
      if (size < 4) begin
        mask = (32'h1 << (8 * size)) - 32'h1;
        v = v & mask;
        if (f3 < 4 && v[8*size-1]) v = v | ~mask;
      end
      o.rdv = v;
    end
  endfunction

  function automatic logic [31:0] mk_inst(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] rd);
    return {12'h000, 5'd1, f3, rd, opc};
  endfunction

  function automatic bundle_t mk(input logic [31:0] inst, input logic [4:0] rd, input logic [31:0] rdv,
                                 input logic [31:0] addr, input logic [31:0] sdata, input logic [31:0] rdata);
    bundle_t b;
    b.pc = $urandom; b.inst = inst; b.valid = 1'b1; b.rd = rd; b.rdv = rdv;
    b.addr = addr; b.sdata = sdata; b.rdata = rdata;
    return b;
  endfunction

  function automatic bundle_t rand_bundle();
    bundle_t b;
    int k;
    logic [2:0] f3;
    k = $urandom_range(0, 9);
    b.pc = $urandom; b.inst = $urandom; b.valid = ($urandom_range(0, 9) != 0);
    b.rd = 5'($urandom); b.rdv = $urandom; b.addr = $urandom;
    b.sdata = $urandom; b.rdata = $urandom;
    if (k < 4)      b.inst[6:0] = 7'h03;
    else if (k < 7) b.inst[6:0] = 7'h23;
    else if (k < 9) b.inst[6:0] = 7'h13;
    f3 = 3'($urandom_range(0, 7));
    if ($urandom_range(0, 4) != 0) begin
      if (k < 4) begin
        f3 = 3'($urandom_range(0, 4));
        if (f3 == 3'd3) f3 = 3'd4; else if (f3 == 3'd4) f3 = 3'd5;
      end else begin
        f3 = 3'($urandom_range(0, 2));
      end
    end
    b.inst[14:12] = f3;
    if ($urandom_range(0, 1) == 0) b.addr[1:0] = 2'b00;
    return b;
  endfunction

  // Present a bundle until the stage captures it; expectations are queued on capture
  task automatic issue(input bundle_t b, input int stall_after);
    bit busy, st, hr;
    int n;
    out_t o;
    req_t r;
    A_PC = b.pc; A_INST = b.inst; A_VALID = b.valid; A_REG_D = b.rd;
    A_REG_D_V = b.rdv; A_MEM_ADDR = b.addr; A_STORE_DATA = b.sdata;
    n = 0;
    do begin
      @(negedge CLK);
      busy = MEM_BUSY; st = STALL;
      @(posedge CLK); #1;
      n++;
      if (busy || st) STALL = ($urandom_range(0, 99) < stall_pct);
    end while ((busy || st) && n < 300);
    if (busy || st) begin
      checks++; errors++;
      $display("FAIL capture_timeout: bundle pc=%h not captured in %0d cycles", b.pc, n);
    end else begin
      if (b.valid) begin
        model(b, o, hr, r);
        exp_q.push_back(o);
        if (hr) req_q.push_back(r);
      end
      A_VALID = 1'b0;
      STALL = ($urandom_range(0, 99) < stall_pct);
      if (stall_after > 0) begin
        STALL = 1'b1;
        repeat (stall_after) begin @(posedge CLK); #1; end
        STALL = 1'b0;
      end
    end
  endtask

  // Monitor: compare every presented output; pop once downstream consumes it
  initial begin
    out_t e;
    forever begin
      @(negedge CLK);
      if (!RST && M_VALID) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: pc=%h rd=%0d val=%h", M_PC, M_REG_D, M_REG_D_V);
        end else begin
          e = exp_q[0];
          if ({M_PC, M_INST, M_REG_D, M_REG_D_V, M_MISALIGN} !== {e.pc, e.inst, e.rd, e.rdv, e.mis}) begin
            errors++;
            $display("FAIL output: got pc=%h inst=%h rd=%0d val=%h mis=%b expected pc=%h inst=%h rd=%0d val=%h mis=%b",
                     M_PC, M_INST, M_REG_D, M_REG_D_V, M_MISALIGN, e.pc, e.inst, e.rd, e.rdv, e.mis);
          end
          if (!STALL) void'(exp_q.pop_front());
        end
      end
    end
  end

  // Memory responder: checks each request cycle, acks after a random delay, injects stray acks
  initial begin
    bit   active;
    int   cnt;
    req_t r;
    logic [68:0] act_v, exp_v;
    active = 1'b0; cnt = 0;
    mem_bus.MEM_ACK = 1'b0;
    mem_bus.MEM_RDATA = '0;
    forever begin
      @(negedge CLK);
      if (!resp_en) begin
        mem_bus.MEM_ACK = man_ack;
        mem_bus.MEM_RDATA = man_rdata;
      end else begin
        mem_bus.MEM_ACK = 1'b0;
        if (mem_bus.MEM_REQ) begin
          checks++;
          if (req_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_request: addr=%h we=%b", mem_bus.MEM_ADDR, mem_bus.MEM_WE);
          end else begin
            r = req_q[0];
            if (!active) begin
              active = 1'b1;
              cnt = (fixed_delay >= 0) ? fixed_delay : $urandom_range(0, 3);
            end
            exp_v = {r.we, r.addr, r.wstrb, r.we ? r.wdata : 32'h0};
            act_v = {mem_bus.MEM_WE, mem_bus.MEM_ADDR, mem_bus.MEM_WSTRB, r.we ? mem_bus.MEM_WDATA : 32'h0};
            if (act_v !== exp_v) begin
              errors++;
              $display("FAIL request: got we/addr/strb/wdata=%h expected %h", act_v, exp_v);
            end
            if (cnt == 0) begin
              mem_bus.MEM_ACK = 1'b1;
              mem_bus.MEM_RDATA = r.rdata;
              void'(req_q.pop_front());
              active = 1'b0;
            end else begin
              cnt--;
            end
          end
        end else if ($urandom_range(0, 7) == 0) begin
          mem_bus.MEM_ACK = 1'b1;
          mem_bus.MEM_RDATA = $urandom;
        end
      end
    end
  end

  initial begin
    bundle_t b;
    int n;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("reset_outputs", {M_VALID, MEM_BUSY, M_MISALIGN, mem_bus.MEM_REQ, mem_bus.MEM_WSTRB, M_REG_D, M_REG_D_V}, 64'h0);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;

    // ADDI pass-through, one-cycle latency
    stall_pct = 0; fixed_delay = 0;
    issue(mk(32'h02A0_0293, 5'd5, 32'h0000_002A, 32'h0, 32'h0, 32'h0), 0);
    @(negedge CLK);
    chk("addi_latency", {M_VALID, mem_bus.MEM_REQ, MEM_BUSY, M_REG_D, M_REG_D_V},
        {1'b1, 1'b0, 1'b0, 5'd5, 32'h0000_002A});
    @(posedge CLK); #1;

    // LB with three REQ cycles, then LBU on the same data
    fixed_delay = 2;
    issue(mk(mk_inst(7'h03, 3'b000, 5'd7), 5'd7, 32'h1234_5678, 32'h0000_1003, 32'h0, 32'h80FF_0000), 0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (i == 0) chk("lb_addr", {mem_bus.MEM_REQ, mem_bus.MEM_WE, mem_bus.MEM_ADDR}, {1'b1, 1'b0, 32'h0000_1000});
      if (!MEM_BUSY) break;
      n++;
    end
    chk("lb_busy_cycles", 64'(n), 64'd3);
    @(posedge CLK); #1;
    issue(mk(mk_inst(7'h03, 3'b100, 5'd8), 5'd8, 32'h0, 32'h0000_1003, 32'h0, 32'h80FF_0000), 0);

    // SH with ack in first REQ cycle, ALU bundle captured back-to-back at end of DONE
    fixed_delay = 0;
    issue(mk(mk_inst(7'h23, 3'b001, 5'd9), 5'd9, 32'h0, 32'h0000_2002, 32'hDEAD_BEEF, 32'h0), 0);
    @(negedge CLK);
    chk("sh_bus", {mem_bus.MEM_REQ, mem_bus.MEM_WE, mem_bus.MEM_WSTRB, mem_bus.MEM_WDATA},
        {1'b1, 1'b1, 4'b1100, 32'hBEEF_BEEF});
    issue(mk(mk_inst(7'h33, 3'b000, 5'd11), 5'd11, 32'h0000_0777, 32'h0, 32'h0, 32'h0), 0);
    @(negedge CLK);
    chk("back_to_back", {M_VALID, MEM_BUSY, M_REG_D, M_REG_D_V}, {1'b1, 1'b0, 5'd11, 32'h0000_0777});
    @(posedge CLK); #1;

    // Misaligned LW never reaches the bus
    issue(mk(mk_inst(7'h03, 3'b010, 5'd12), 5'd12, 32'hFFFF_FFFF, 32'h0000_3001, 32'h0, 32'h0), 0);
    @(negedge CLK);
    chk("lw_misalign", {M_VALID, M_MISALIGN, mem_bus.MEM_REQ, M_REG_D, M_REG_D_V},
        {1'b1, 1'b1, 1'b0, 5'd0, 32'h0});
    @(posedge CLK); #1;

    // STALL through REQ and past the ack: DONE output held until release
    fixed_delay = 1;
    issue(mk(mk_inst(7'h03, 3'b010, 5'd13), 5'd13, 32'h0, 32'h0000_4000, 32'h0, 32'hCAFE_F00D), 5);
    @(negedge CLK);
    chk("stall_done_held", {M_VALID, MEM_BUSY, M_REG_D, M_REG_D_V}, {1'b1, 1'b0, 5'd13, 32'hCAFE_F00D});
    @(posedge CLK); #1;

    // Randomized traffic with stalls, gaps and random ack latency
    stall_pct = 25; fixed_delay = -1;
    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 5) == 0) begin
        repeat ($urandom_range(1, 3)) begin @(posedge CLK); #1; end
      end
      b = rand_bundle();
      issue(b, ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : 0);
    end
    STALL = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (exp_q.size() == 0 && req_q.size() == 0) break;
    end
    chk("drain_outputs", 64'(exp_q.size()), 64'd0);
    chk("drain_requests", 64'(req_q.size()), 64'd0);

    // Reset in the second REQ cycle; the late ack must be ignored
    resp_en = 1'b0; man_ack = 1'b0;
    A_PC = 32'h0000_0100; A_INST = mk_inst(7'h03, 3'b010, 5'd14); A_VALID = 1'b1;
    A_REG_D = 5'd14; A_REG_D_V = '0; A_MEM_ADDR = 32'h0000_0040; A_STORE_DATA = '0;
    @(negedge CLK);
    A_VALID = 1'b0;
    chk("rst_req1", {mem_bus.MEM_REQ, MEM_BUSY, M_VALID}, {1'b1, 1'b1, 1'b0});
    @(negedge CLK);
    chk("rst_req2", {mem_bus.MEM_REQ, MEM_BUSY}, {1'b1, 1'b1});
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0; man_ack = 1'b1; man_rdata = 32'h5555_AAAA;
    chk("rst_after", {mem_bus.MEM_REQ, M_VALID, MEM_BUSY, M_MISALIGN}, 64'h0);
    @(negedge CLK);
    man_ack = 1'b0;
    chk("rst_ack_ignored", {mem_bus.MEM_REQ, M_VALID, MEM_BUSY}, 64'h0);
    @(negedge CLK);
    chk("rst_idle", {mem_bus.MEM_REQ, M_VALID, MEM_BUSY, M_REG_D_V}, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
